// File: rtl/match_countdown_timer_if.sv
// match_countdown_timer_if
//   Groups the control inputs and display/status outputs of the match clock.
//   master : game controller / display side (drives start/stop/load)
//   slave  : the timer itself
//   start, stop, load          : control levels, sampled every clk edge
//   sec_ones/sec_tens/min_ones/min_tens : BCD digits of the remaining time
//   running, done              : state flags (RUN, DONE)
//   expired                    : one-cycle pulse when 00:00 is reached
interface match_countdown_timer_if;
  logic       start;
  logic       stop;
  logic       load;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       done;
  logic       expired;

  modport master (
    output start, stop, load,
    input  sec_ones, sec_tens, min_ones, min_tens, running, done, expired
  );

  modport slave (
    input  start, stop, load,
    output sec_ones, sec_tens, min_ones, min_tens, running, done, expired
  );
endinterface

// File: rtl/match_countdown_timer.sv
// match_countdown_timer
//   Down-counting mm:ss match clock. A prescaler divides clk by TICK_DIV;
//   each wrap decrements a borrow-chained set of BCD digits until 00:00.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-low
//     bus   : match_countdown_timer_if.slave (controls, digits, status)
//   Parameters: TICK_DIV (>=2), START_MIN (0..99), START_SEC (0..59)
module match_countdown_timer #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int START_MIN = 2,
  parameter int START_SEC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  match_countdown_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

  localparam logic [3:0] PRE_MT = 4'(START_MIN / 10);
  localparam logic [3:0] PRE_MO = 4'(START_MIN % 10);
  localparam logic [2:0] PRE_ST = 3'(START_SEC / 10);
  localparam logic [3:0] PRE_SO = 4'(START_SEC % 10);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q,    state_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [2:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic          running_q,  running_d;
  logic          done_q,     done_d;
  logic          expired_q,  expired_d;

  // Decremented time (borrow chain) and zero detection.
  logic [3:0] dec_so;
  logic [2:0] dec_st;
  logic [3:0] dec_mo;
  logic [3:0] dec_mt;
  logic       b_so, b_st, b_mo;
  logic       at_zero, dec_zero;

  always_comb begin
    b_so   = (sec_ones_q == 4'd0);
    dec_so = b_so ? 4'd9 : sec_ones_q - 4'd1;

    b_st   = b_so && (sec_tens_q == 3'd0);
    dec_st = sec_tens_q;
    if (b_so) dec_st = (sec_tens_q == 3'd0) ? 3'd5 : sec_tens_q - 3'd1;

    b_mo   = b_st && (min_ones_q == 4'd0);
    dec_mo = min_ones_q;
    if (b_st) dec_mo = (min_ones_q == 4'd0) ? 4'd9 : min_ones_q - 4'd1;

    // Never decremented at 00:00, so min_tens cannot underflow.
    dec_mt = b_mo ? min_tens_q - 4'd1 : min_tens_q;

    at_zero  = (sec_ones_q == 4'd0) && (sec_tens_q == 3'd0) &&
               (min_ones_q == 4'd0) && (min_tens_q == 4'd0);
    dec_zero = (dec_so == 4'd0) && (dec_st == 3'd0) &&
               (dec_mo == 4'd0) && (dec_mt == 4'd0);
  end

  // Next-state logic; priority load > stop > start > tick.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    expired_d  = 1'b0;

    if (bus.load) begin
      state_d    = S_IDLE;
      presc_d    = '0;
      sec_ones_d = PRE_SO;
      sec_tens_d = PRE_ST;
      min_ones_d = PRE_MO;
      min_tens_d = PRE_MT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.stop && bus.start) begin
            if (at_zero) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          // Stop on a wrap edge leaves the prescaler at TICK_MAX, so the
          // first RUN cycle after resuming performs the held-off decrement.
          if (bus.stop) begin
            state_d = S_PAUSE;
          end else if (presc_q == TICK_MAX) begin
            presc_d    = '0;
            sec_ones_d = dec_so;
            sec_tens_d = dec_st;
            min_ones_d = dec_mo;
            min_tens_d = dec_mt;
            if (dec_zero) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (!bus.stop && bus.start) state_d = S_RUN;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      sec_ones_q <= PRE_SO;
      sec_tens_q <= PRE_ST;
      min_ones_q <= PRE_MO;
      min_tens_q <= PRE_MT;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      done_q     <= done_d;
      expired_q  <= expired_d;
    end
  end

  assign bus.sec_ones = sec_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.min_ones = min_ones_q;
  assign bus.min_tens = min_tens_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.expired  = expired_q;

endmodule
